// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT round engine: S-box, bit permutation and FSM encoding.
package present_pkg;

   localparam int BLOCK_WIDTH = 64;

   // Nibble n of this constant holds S(n), so S(0)=C sits in the least significant nibble.
   localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } fsm_state_t;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [63:0] sbox64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[n*4 +: 4] = sbox4(x[n*4 +: 4]);
      end
      return y;
   endfunction

   // Bit i lands on (16*i) mod 63; the top bit is a fixed point.
   function automatic logic [63:0] player64(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) begin
         y[(16*i) % 63] = x[i];
      end
      return y;
   endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT key-schedule step for 80- or 128-bit keys.
module present_key_schedule
   import present_pkg::*;
#(
   parameter int KEY_WIDTH = 80
) (
   input  logic [KEY_WIDTH-1:0] keyreg,
   input  logic [4:0]           rc,
   output logic [KEY_WIDTH-1:0] next_key,
   output logic [63:0]          round_key
);

   logic [KEY_WIDTH-1:0] rotated;

   assign rotated   = {keyreg[KEY_WIDTH-62:0], keyreg[KEY_WIDTH-1 -: 61]};
   assign round_key = keyreg[KEY_WIDTH-1 -: 64];

   // The wide key passes two nibbles through the S-box and mixes rc in lower down.
   if (KEY_WIDTH == 128) begin : g_k128
      assign next_key = {sbox4(rotated[127:124]), sbox4(rotated[123:120]),
                         rotated[119:67], rotated[66:62] ^ rc, rotated[61:0]};
   end else begin : g_k80
      assign next_key = {sbox4(rotated[79:76]), rotated[75:20],
                         rotated[19:15] ^ rc, rotated[14:0]};
   end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT encryption core: one full round per clock with a start/done handshake.
module present_round_engine
   import present_pkg::*;
#(
   parameter int KEY_WIDTH = 80,
   parameter int ROUNDS    = 31
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [63:0]            plaintext,
   input  logic [KEY_WIDTH-1:0]   key,
   output logic                   busy,
   output logic                   done,
   output logic [63:0]            ciphertext
);

   if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key
      $error("present_round_engine: KEY_WIDTH must be 80 or 128");
   end
   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_round_engine: ROUNDS must be in 1..31");
   end

   localparam logic [4:0] LAST_RC = 5'(ROUNDS);

   fsm_state_t                 fsm;
   fsm_state_t                 fsm_next;
   logic [BLOCK_WIDTH-1:0]     data;
   logic [KEY_WIDTH-1:0]       keyreg;
   logic [KEY_WIDTH-1:0]       next_key;
   logic [63:0]                round_key;
   logic [4:0]                 rc;

   present_key_schedule #(
      .KEY_WIDTH (KEY_WIDTH)
   ) u_key_schedule (
      .keyreg    (keyreg),
      .rc        (rc),
      .next_key  (next_key),
      .round_key (round_key)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (start) fsm_next = ROUND;
         ROUND:   if (rc == LAST_RC) fsm_next = FINAL;
         FINAL:   fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // busy is only re-evaluated in IDLE, so it stays high through the done cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data       <= '0;
         keyreg     <= '0;
         rc         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ciphertext <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               busy <= start;
               if (start) begin
                  data   <= plaintext;
                  keyreg <= key;
                  rc     <= 5'd1;
               end
            end
            ROUND: begin
               data   <= player64(sbox64(data ^ round_key));
               keyreg <= next_key;
               rc     <= rc + 5'd1;
            end
            FINAL: begin
               ciphertext <= data ^ round_key;
               done       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_present_round_engine.sv
// Bench for present_round_engine: 80-bit, 128-bit and single-round instances checked by a scoreboard.
module tb_present_round_engine;

   typedef struct {
      logic [63:0]  pt;
      logic [127:0] key;
      int           which;
      logic [63:0]  ct;
   } vec_t;

   logic         clock = 1'b0;
   logic         reset;

   logic         start_a, busy_a, done_a;
   logic [63:0]  pt_a, ct_a;
   logic [79:0]  key_a;
   logic         start_b, busy_b, done_b;
   logic [63:0]  pt_b, ct_b;
   logic [127:0] key_b;
   logic         start_c, busy_c, done_c;
   logic [63:0]  pt_c, ct_c;
   logic [79:0]  key_c;

   logic [63:0]  exp_a[$];
   logic [63:0]  exp_b[$];
   logic [63:0]  exp_c[$];
   int           total = 0;
   int           bad = 0;
   vec_t         vecs[8];

   always #5 clock = ~clock;

   present_round_engine #(.KEY_WIDTH(80), .ROUNDS(31)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .plaintext(pt_a), .key(key_a),
      .busy(busy_a), .done(done_a), .ciphertext(ct_a));

   present_round_engine #(.KEY_WIDTH(128), .ROUNDS(31)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .plaintext(pt_b), .key(key_b),
      .busy(busy_b), .done(done_b), .ciphertext(ct_b));

   present_round_engine #(.KEY_WIDTH(80), .ROUNDS(1)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .plaintext(pt_c), .key(key_c),
      .busy(busy_c), .done(done_c), .ciphertext(ct_c));

   function automatic logic [3:0] ref_sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   // Reference cipher; the permutation is written as a gather using the inverse map 4*j mod 63.
   function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [127:0] key_in,
                                               input int kw, input int rounds);
      logic [63:0]  s, t, rk;
      logic [79:0]  k80;
      logic [127:0] k128;
      logic [4:0]   rc5;
      s = pt;
      k80 = key_in[79:0];
      k128 = key_in;
      for (int r = 1; r <= rounds; r++) begin
         rk = (kw == 80) ? k80[79:16] : k128[127:64];
         s = s ^ rk;
         for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_sbox(s[4*n +: 4]);
         for (int j = 0; j < 63; j++) t[j] = s[(4*j) % 63];
         t[63] = s[63];
         s = t;
         rc5 = 5'(r);
         k80 = (k80 << 61) | (k80 >> 19);
         k80[79:76] = ref_sbox(k80[79:76]);
         k80[19:15] = k80[19:15] ^ rc5;
         k128 = (k128 << 61) | (k128 >> 67);
         k128[127:124] = ref_sbox(k128[127:124]);
         k128[123:120] = ref_sbox(k128[123:120]);
         k128[66:62] = k128[66:62] ^ rc5;
      end
      rk = (kw == 80) ? k80[79:16] : k128[127:64];
      return s ^ rk;
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic int rounds_of(input int which);
      return (which == 2) ? 1 : 31;
   endfunction

   function automatic logic busy_of(input int which);
      case (which)
         0: return busy_a;
         1: return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic done_of(input int which);
      case (which)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic set_start(input int which, input logic s, input logic [63:0] pt, input logic [127:0] key);
      case (which)
         0: begin start_a = s; pt_a = pt; key_a = key[79:0]; end
         1: begin start_b = s; pt_b = pt; key_b = key; end
         default: begin start_c = s; pt_c = pt; key_c = key[79:0]; end
      endcase
   endtask

   task automatic push_expected(input int which, input logic [63:0] ct);
      case (which)
         0: exp_a.push_back(ct);
         1: exp_b.push_back(ct);
         default: exp_c.push_back(ct);
      endcase
   endtask

   // Scoreboard monitors: every done pops one expected ciphertext.
   always @(negedge clock) begin
      if (done_a) begin
         if (exp_a.size() == 0) check_output("unexpected_done_a", 64'h1, 64'h0);
         else check_output("ciphertext_a", ct_a, exp_a.pop_front());
      end
      if (done_b) begin
         if (exp_b.size() == 0) check_output("unexpected_done_b", 64'h1, 64'h0);
         else check_output("ciphertext_b", ct_b, exp_b.pop_front());
      end
      if (done_c) begin
         if (exp_c.size() == 0) check_output("unexpected_done_c", 64'h1, 64'h0);
         else check_output("ciphertext_c", ct_c, exp_c.pop_front());
      end
   end

   task automatic apply_stimulus(input vec_t v);
      int k;
      @(negedge clock);
      set_start(v.which, 1'b1, v.pt, v.key);
      push_expected(v.which, v.ct);
      @(negedge clock);
      set_start(v.which, 1'b0, 64'h0, 128'h0);
      check_output("busy_after_start", 64'(busy_of(v.which)), 64'h1);
      k = 0;
      while (k <= rounds_of(v.which) + 4 && !done_of(v.which)) begin
         @(negedge clock);
         k++;
      end
      check_output("done_latency", 64'(k), 64'(rounds_of(v.which) + 1));
      check_output("busy_during_done", 64'(busy_of(v.which)), 64'h1);
      @(negedge clock);
      check_output("done_single_pulse", 64'(done_of(v.which)), 64'h0);
      check_output("busy_released", 64'(busy_of(v.which)), 64'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   marks[$];
      int   n;
      logic [127:0] rkey;
      logic [63:0]  rpt;

      reset = 1'b1;
      set_start(0, 1'b0, 64'h0, 128'h0);
      set_start(1, 1'b0, 64'h0, 128'h0);
      set_start(2, 1'b0, 64'h0, 128'h0);

      vecs[0] = '{pt: 64'h0, key: 128'h0, which: 0, ct: 64'h5579C1387B228445};
      vecs[1] = '{pt: 64'h0, key: {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, which: 0, ct: 64'hE72C46C0F5945049};
      vecs[2] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: 128'h0, which: 0, ct: 64'hA112FFC72F68417B};
      vecs[3] = '{pt: 64'hFFFFFFFFFFFFFFFF, key: {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, which: 0, ct: 64'h3333DCD3213210D2};
      vecs[4] = '{pt: 64'h0, key: 128'h0, which: 1, ct: 64'h96DB702A2E6900AF};
      vecs[5] = '{pt: 64'h0, key: 128'h0, which: 2, ct: ref_encrypt(64'h0, 128'h0, 80, 1)};
      rpt  = {$urandom, $urandom};
      rkey = {48'h0, 16'($urandom), $urandom, $urandom};
      vecs[6] = '{pt: rpt, key: rkey, which: 0, ct: ref_encrypt(rpt, rkey, 80, 31)};
      rpt  = {$urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      vecs[7] = '{pt: rpt, key: rkey, which: 1, ct: ref_encrypt(rpt, rkey, 128, 31)};

      repeat (3) @(negedge clock);
      check_output("reset_busy", 64'(busy_a), 64'h0);
      check_output("reset_done", 64'(done_a), 64'h0);
      check_output("reset_ciphertext", ct_a, 64'h0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

      // start held high: one block every ROUNDS+2 cycles, starts while busy ignored
      @(negedge clock);
      set_start(0, 1'b1, 64'h0, 128'h0);
      repeat (3) exp_a.push_back(64'h5579C1387B228445);
      n = 0;
      while (marks.size() < 3 && n < 3 * 33 + 10) begin
         @(negedge clock);
         n++;
         if (done_a) marks.push_back(n);
      end
      set_start(0, 1'b0, 64'h0, 128'h0);
      check_output("continuous_done_count", 64'(marks.size()), 64'd3);
      if (marks.size() == 3) begin
         check_output("continuous_first_done", 64'(marks[0]), 64'd33);
         check_output("continuous_period_1", 64'(marks[1] - marks[0]), 64'd33);
         check_output("continuous_period_2", 64'(marks[2] - marks[1]), 64'd33);
      end
      repeat (2) @(negedge clock);
      check_output("continuous_idle_busy", 64'(busy_a), 64'h0);

      // reset in the middle of an encryption discards it
      @(negedge clock);
      set_start(0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 128'h0);
      @(negedge clock);
      set_start(0, 1'b0, 64'h0, 128'h0);
      repeat (9) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check_output("midreset_busy", 64'(busy_a), 64'h0);
      check_output("midreset_done", 64'(done_a), 64'h0);
      check_output("midreset_ciphertext", ct_a, 64'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      check_output("midreset_stays_idle", 64'(busy_a), 64'h0);
      apply_stimulus(vecs[3]);

      repeat (3) @(negedge clock);
      check_output("leftover_expected", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
